multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main sequencer for the multicycle CPU core. Decodes the instruction register fields and steps a one-hot-equivalent state machine through fetch, decode, execute, memory and writeback. It drives the unconditional datapath selects directly and produces the raw `pcs`, `reg_w`, `mem_w`, `flag_w`, `branch` and `no_write` requests consumed by the condition-logic block. It also waits on a memory ready handshake in every memory-access state.

## Interface
- `STATE_W`, 4, width of the exported state register (10 states used)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge
- `op` in 2: instr[27:26]; 00 data-proc, 01 memory, 10 branch, 11 undefined
- `funct` in 6: instr[25:20]; [5]=I (immediate), [4:1]=cmd, [0]=S (data-proc) / L (memory)
- `rd` in 4: instr[15:12], destination register
- `mem_ready` in 1: memory completes the current access this cycle
- `pc_write` out 1: unconditional PC load (PC+4 in FETCH)
- `adr_src` out 1: 0=PC, 1=ALU result as memory address
- `ir_write` out 1: load instruction register
- `alu_src_a` out 1: 0=Rn, 1=PC
- `alu_src_b` out 2: 00=Rm, 01=extended immediate, 10=constant 4
- `result_src` out 2: 00=ALU out register, 01=read data, 10=ALU result (bypass)
- `alu_ctrl` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR
- `pcs` out 1: PC written from result (rd==15 writeback or branch)
- `reg_w`, `mem_w`, `branch`, `no_write` out 1: raw requests to condition logic
- `flag_w` out 2: [1]=N,Z update, [0]=C,V update
- `instr_done` out 1: one-cycle pulse in the final state of each instruction
- `state` out STATE_W: current state, for debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 are illegal and go to FETCH next cycle with all outputs 0.
- FETCH: `adr_src`=0, `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl`=00, `result_src`=10. `ir_write`=`pc_write`=`mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alu_src_a`=1, `alu_src_b`=10, `result_src`=10 (PC+8 presented as R15).
  - op 01 → MEMADR.
  - op 00 → EXECI if `funct[5]`, else EXECR.
  - op 10 → BRANCH.
  - op 11 → FETCH with `instr_done`=1 (treated as NOP).
- MEMADR: `alu_src_a`=0, `alu_src_b`=01, ADD. Goes to MEMREAD if L=1, else MEMWRITE.
- MEMREAD: `adr_src`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_w`=1, `pcs`=(rd==15), `instr_done`=1, then FETCH.
- MEMWRITE: `adr_src`=1, `mem_w`=1. `mem_w` is held while `mem_ready`=0. On `mem_ready`=1: `instr_done`=1, then FETCH.
- EXECR / EXECI: `alu_src_a`=0, `alu_src_b`=00 / 01. Then ALUWB.
  - `alu_ctrl` from cmd: 0100→00, 0010→01, 0000→10, 1100→11, 1010 (CMP)→01. Any other cmd → 00.
  - `flag_w[1]`=S; `flag_w[0]`=S & (cmd ∈ {0100, 0010, 1010}). These are asserted in the execute state only.
- ALUWB: `result_src`=00, `reg_w`=1, `pcs`=(rd==15), `instr_done`=1, then FETCH.
  - `no_write`=1 when cmd=1010 or cmd is undecoded.
- BRANCH: `alu_src_a`=0, `alu_src_b`=01, ADD, `result_src`=10, `branch`=1, `pcs`=1, `instr_done`=1, then FETCH.
- Any output not listed for a state is 0.

## Timing
- `state` is the only register. All other outputs are combinational from `state`, `op`, `funct`, `rd` and `mem_ready`.
- `reset`=0 at an edge forces `state`=FETCH regardless of the current state, including mid-MEMWRITE. After reset, outputs take their FETCH values: `ir_write`/`pc_write` follow `mem_ready`, everything else is 0 except the selects above.
- Latency with `mem_ready` held at 1, FETCH to the next FETCH:
  - data-proc 4 cycles
  - LDR 5 cycles
  - STR 4 cycles
  - B 3 cycles
  - undefined 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `instr_done` is high for exactly one cycle per instruction.
- `flag_w` is high for exactly one cycle, in EXECR/EXECI.

## Test plan
- Reset: hold `reset`=0 for 2 cycles from an arbitrary state, then release with `mem_ready`=1. Expect `state`=0 and `ir_write`=1 in the first cycle, and `state`=1 in the next.
- ADDS R1,R2,R3 (op 00, funct 001001, rd 1): state sequence 0,1,6,8. In state 6: `alu_ctrl`=00 and `flag_w`=11. In state 8: `reg_w`=1, `pcs`=0, `no_write`=0, `instr_done`=1.
- CMP immediate (funct 110101): states 0,1,7,8 with `alu_ctrl`=01, `flag_w`=11, then `no_write`=1 in ALUWB.
- LDR to R15 with `mem_ready`=0 for 3 cycles in MEMREAD: states 0,1,2,3,3,3,3,4 (3 repeated for the wait cycles, 8 cycles total). MEMWB shows `result_src`=01, `reg_w`=1, `pcs`=1.
- STR with `mem_ready`=0 for 2 cycles in FETCH: FETCH is held for 3 cycles with `ir_write`=0 until ready. Then `mem_w`=1 is held for the whole MEMWRITE state, and `instr_done` pulses once.
- B and op 11: B gives states 0,1,9 with `branch`=`pcs`=1. op 11 gives 0,1 then FETCH with `instr_done`=1 in DECODE and no `reg_w`/`mem_w`.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main sequencer for the multicycle core: decodes IR fields and steps
// fetch/decode/execute/memory/writeback, raising raw requests for condition logic.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_ctrl,
    output logic               pcs,
    output logic               reg_w,
    output logic               mem_w,
    output logic [1:0]         flag_w,
    output logic               branch,
    output logic               no_write,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     st;
    state_t     nxt;
    logic [3:0] cmd;
    logic       s_bit;
    logic       i_bit;
    logic       l_bit;
    logic [1:0] dp_ctrl;
    logic       dp_known;
    logic       dp_arith;
    logic       rd_pc;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign l_bit = funct[0];
    assign i_bit = funct[5];
    assign rd_pc = (rd == 4'hF);
    assign state = STATE_W'(st);

    always_comb begin
        dp_ctrl  = 2'b00;
        dp_known = 1'b1;
        dp_arith = 1'b0;
        case (cmd)
            4'b0100: begin dp_ctrl = 2'b00; dp_arith = 1'b1; end
            4'b0010: begin dp_ctrl = 2'b01; dp_arith = 1'b1; end
            4'b1010: begin dp_ctrl = 2'b01; dp_arith = 1'b1; end
            4'b0000: dp_ctrl = 2'b10;
            4'b1100: dp_ctrl = 2'b11;
            default: dp_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) st <= FETCH;
        else        st <= nxt;
    end

    always_comb begin
        nxt        = FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_ctrl   = 2'b00;
        pcs        = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        flag_w     = 2'b00;
        branch     = 1'b0;
        no_write   = 1'b0;
        instr_done = 1'b0;
        case (st)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                nxt        = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // PC+8 is presented on the result bus as R15
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   nxt = MEMADR;
                    2'b00:   nxt = i_bit ? EXECI : EXECR;
                    2'b10:   nxt = BRANCH;
                    default: begin
                        nxt        = FETCH;
                        instr_done = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                nxt       = l_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                pcs        = rd_pc;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                instr_done = mem_ready;
                nxt        = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR, EXECI: begin
                alu_src_b = (st == EXECI) ? 2'b01 : 2'b00;
                alu_ctrl  = dp_ctrl;
                flag_w    = {s_bit, s_bit & dp_arith};
                nxt       = ALUWB;
            end
            ALUWB: begin
                reg_w      = 1'b1;
                pcs        = rd_pc;
                instr_done = 1'b1;
                no_write   = (cmd == 4'b1010) | ~dp_known;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                pcs        = 1'b1;
                instr_done = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule
